crc_engine: RTL
===============

# crc_engine

Parametrised, sequential CRC engine that supersedes the fixed CRC-5/CRC-8 single-step logic. The polynomial width and value, the initial value and the beat width are all parameters. The block accepts message beats over a valid/ready handshake and divides them one bit per clock, MSB first, using augmented (shift-in) division. At end of frame it either emits the CRC (generate mode) or reports whether the received CRC matched (check mode). It sits between a byte/word framer and the link layer.

## Interface
- CRC_W, 8, CRC width in bits (2..32)
- POLY, 8'h31, generator polynomial without the implicit x^CRC_W term
- INIT, 0, remainder value at reset, `clr` and frame start
- DATA_W, 8, bits per input beat (1..64)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous abort: drop the current frame and reload INIT
- in_valid  in  1  beat valid
- in_ready  out  1  engine can accept a beat
- in_data  in  DATA_W  beat payload; bit DATA_W-1 is shifted first
- in_last  in  1  beat is the last of the frame
- mode  in  1  0 = generate, 1 = check; sampled on the first beat of a frame
- out_valid  out  1  one-cycle result strobe
- out_crc  out  CRC_W  final remainder
- out_ok  out  1  check result (remainder == 0); valid with out_valid
- busy  out  1  a frame is in progress (state ≠ ACCEPT, or a frame is partially received)

## Operation
- Per-bit update: fb = rem[CRC_W-1]; rem ← {rem[CRC_W-2:0], bit} ^ (fb ? POLY : 0).
- States:
  - ACCEPT: in_ready = !clr. On handshake (in_valid & in_ready):
    - capture in_data into the shift register and in_last into last_q;
    - if this is the first beat of the frame, also capture mode into mode_q;
    - go to SHIFT with bitcnt = DATA_W-1.
  - SHIFT: shift one data bit per cycle. After bitcnt reaches 0, go to FLUSH with bitcnt = CRC_W-1 if last_q is set, otherwise return to ACCEPT.
  - FLUSH: shift CRC_W zero bits, one per cycle, then go to DONE.
  - DONE: drive out_valid = 1 for one cycle, with out_crc = rem and out_ok = mode_q & (rem == 0). Then go to ACCEPT with rem = INIT and the frame-start flag set.
- Generate mode: out_crc is the CRC of the message. Check mode: the frame carries message followed by its CRC, padded in the final beat(s); out_ok = 1 on a match.
- out_crc and out_ok hold their values until the next DONE, rst or clr.
- Priority: rst > clr > handshake.
  - clr in any state: state ← ACCEPT, rem ← INIT, out_valid/out_crc/out_ok ← 0, frame-start flag ← 1.
  - in_ready is forced low while clr is high, so no beat is accepted in that cycle.
- in_data, in_last and mode are ignored outside a handshake.
- A frame of any length ≥ 1 beat is supported; there is no internal length limit.

## Timing
- Reset values: in_ready 0 while rst is high and 1 in the first cycle after; out_valid 0, out_crc 0, out_ok 0, busy 0; rem = INIT; state ACCEPT.
- Throughput: one beat per DATA_W+1 cycles. in_ready is low for exactly DATA_W cycles after each accept.
- Latency: out_valid rises DATA_W+CRC_W+1 clock edges after the handshake edge of the last beat.
- After out_valid, in_ready is high in the following cycle. A new frame may be accepted in that cycle.
- rst or clr mid-SHIFT or mid-FLUSH discards the frame; no out_valid is produced for it.

## Configuration
- CRC_CHECK_EN defined: check mode is compiled in. mode is sampled and out_ok is computed as described.
- CRC_CHECK_EN undefined: mode is ignored (always generate), out_ok is tied to 0, and the ports remain present.

## Test plan
- CRC_W=8, POLY=8'h31, INIT=0, mode=0. One beat 0x01 with last=1 → out_crc=0x31 exactly 17 edges after the handshake; out_ok=0.
- Same configuration, beat 0x80 → out_crc=0x7A. Beat 0x00 → out_crc=0x00.
- Check mode (CRC_CHECK_EN): beats 0x01 then 0x31 (last) → out_ok=1. Beats 0x01 then 0x30 → out_ok=0, out_crc≠0.
- CRC_W=5, POLY=5'h05, DATA_W=8, beat 0x01 → out_crc=5'h05 exactly 14 edges after the handshake.
- Handshake: in_valid held high for a 2-beat frame → in_ready low for 8 cycles after each accept, and exactly one out_valid pulse.
- clr asserted on the 4th SHIFT cycle, then beat 0x01 (last) → no result for the aborted frame; the next result is 0x31. clr together with in_valid → beat not accepted.

Source files
------------

// File: rtl/crc_engine.sv
// crc_engine: parametrised bit-serial CRC engine (augmented shift-in division,
// MSB first, one bit per clock).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 synchronous abort, reloads INIT and drops the frame
//   in_valid/in_ready   beat handshake; in_data (DATA_W), in_last, mode
//   out_valid           one-cycle result strobe
//   out_crc, out_ok     final remainder and check result, held until next result
//   busy                frame in progress
//
// Build option: CRC_CHECK_EN compiles in check mode (mode sampling and out_ok).
// Without it mode is ignored and out_ok stays 0.
module crc_engine #(
  parameter int unsigned       CRC_W  = 8,
  parameter logic [CRC_W-1:0]  POLY   = CRC_W'(32'h31),
  parameter logic [CRC_W-1:0]  INIT   = '0,
  parameter int unsigned       DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              mode,
  output logic              out_valid,
  output logic [CRC_W-1:0]  out_crc,
  output logic              out_ok,
  output logic              busy
);

  localparam int unsigned CNT_MAX = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SHIFT  = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CRC_W-1:0]    rem;
  logic [DATA_W-1:0]   sr;
  logic [CNT_W-1:0]    bitcnt;
  logic                last_q;
  logic                first_q;
  logic                hs;
  logic                cnt_zero;

`ifdef CRC_CHECK_EN
  logic                mode_q;
`else
  logic                unused_mode;
  assign unused_mode = mode;
`endif

  // One step of polynomial division: shift in a bit, subtract POLY on carry-out.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                input logic             b);
    return {r[CRC_W-2:0], b} ^ (r[CRC_W-1] ? POLY : '0);
  endfunction

  assign hs       = in_valid & in_ready;
  assign cnt_zero = (bitcnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCEPT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCEPT;
    end else begin
      unique case (state_q)
        ACCEPT: if (hs)       state_d = SHIFT;
        SHIFT:  if (cnt_zero) state_d = last_q ? FLUSH : ACCEPT;
        FLUSH:  if (cnt_zero) state_d = DONE;
        DONE:                 state_d = ACCEPT;
        default:              state_d = ACCEPT;
      endcase
    end
  end

  // Combinational status outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    in_ready = !rst && !clr && (state_q == ACCEPT);
    busy     = (state_q != ACCEPT) || !first_q;
  end

  // Datapath and registered results
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rem       <= INIT;
      sr        <= '0;
      bitcnt    <= '0;
      last_q    <= 1'b0;
      first_q   <= 1'b1;
      out_valid <= 1'b0;
      out_crc   <= '0;
      out_ok    <= 1'b0;
`ifdef CRC_CHECK_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        ACCEPT: begin
          if (hs) begin
            sr      <= in_data;
            last_q  <= in_last;
            first_q <= 1'b0;
            bitcnt  <= CNT_W'(DATA_W - 1);
`ifdef CRC_CHECK_EN
            if (first_q) mode_q <= mode;
`endif
          end
        end
        SHIFT: begin
          rem <= crc_step(rem, sr[DATA_W-1]);
          sr  <= sr << 1;
          // Preload the flush count on the last data bit; harmless if not last.
          bitcnt <= cnt_zero ? CNT_W'(CRC_W - 1) : bitcnt - CNT_W'(1);
        end
        FLUSH: begin
          rem    <= crc_step(rem, 1'b0);
          bitcnt <= bitcnt - CNT_W'(1);
        end
        DONE: begin
          out_valid <= 1'b1;
          out_crc   <= rem;
`ifdef CRC_CHECK_EN
          out_ok    <= mode_q && (rem == '0);
`else
          out_ok    <= 1'b0;
`endif
          rem       <= INIT;
          first_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
